bin2bcd_seq: RTL

- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method.
- Sits between an arithmetic result (e.g. the 4-bit adder's {carry,sum}, zero-extended) and the FND digit mux / BCD-to-segment stage.
- Replaces the combinational divide/modulo digit splitter with a small iterative datapath.
- Start/done handshake; results are held stable between conversions.

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_add3.sv | 22 ++
 rtl/bin2bcd_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared types and constants for the sequential binary-to-BCD path.
// Rev    : 1.0  initial release
// ============================================================================
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module : bcd_add3
// Brief  : Double-dabble correction cell: digits of 5 or more get +3 (mod 16).
// Rev    : 1.0  initial release
// ============================================================================
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_d,
    output logic [BCD_W-1:0] o_d
);

    always_comb begin
        o_d = i_d;
        if (i_d >= BCD_W'(5)) begin
            o_d = i_d + BCD_W'(3);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module : bin2bcd_seq
// Brief  : Iterative shift-add-3 binary-to-BCD converter with start/done
//          handshake and saturation to all nines on overflow.
// Rev    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH = 14,
    parameter int DIGITS   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [IN_WIDTH-1:0]       i_bin,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      ovf,
    output logic [DIGITS*BCD_W-1:0]   o_bcd
);

    localparam int                 c_SCR_W    = DIGITS * BCD_W;
    localparam int                 c_CAT_W    = c_SCR_W + IN_WIDTH;
    localparam int                 c_CNT_W    = $clog2(IN_WIDTH + 1);
    localparam logic [31:0]        c_MAX      = pow10(DIGITS) - 32'd1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(IN_WIDTH);
    localparam logic [c_SCR_W-1:0] c_SAT      = {DIGITS{4'h9}};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IN_WIDTH-1:0]  r_shift;
    logic [c_SCR_W-1:0]   r_scr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_ovf_pend;
    logic [c_SCR_W-1:0]   r_bcd;
    logic                 r_ovf;
    logic                 r_done;

    logic [c_SCR_W-1:0]   w_adj;
    logic [c_CAT_W-1:0]   w_cat;
    logic                 w_in_ovf;
    logic                 w_load;
    logic                 w_step;
    logic                 w_last;

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_add3
            bcd_add3 u_add3 (
                .i_d (r_scr[d*BCD_W +: BCD_W]),
                .o_d (w_adj[d*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // Correct then shift the joint {scratch, shift} register; the scratch MSB
    // falls off, which only matters for inputs that saturate anyway.
    assign w_cat    = {w_adj, r_shift} << 1;
    assign w_in_ovf = ({{(32-IN_WIDTH){1'b0}}, i_bin} > c_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_cnt == c_CNT_W'(1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_scr      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_shift    <= i_bin;
                r_scr      <= '0;
                r_cnt      <= c_CNT_INIT;
                r_ovf_pend <= w_in_ovf;
            end
            if (w_step) begin
                r_scr   <= w_cat[c_CAT_W-1:IN_WIDTH];
                r_shift <= w_cat[IN_WIDTH-1:0];
                r_cnt   <= r_cnt - c_CNT_W'(1);
                if (w_last) begin
                    r_done <= 1'b1;
                    r_ovf  <= r_ovf_pend;
                    r_bcd  <= r_ovf_pend ? c_SAT : w_cat[c_CAT_W-1:IN_WIDTH];
                end
            end
        end
    end

    assign done  = r_done;
    assign ovf   = r_ovf;
    assign o_bcd = r_bcd;

endmodule
`default_nettype wire
